// File: rtl/ring_inject_fifo.sv
// ring_inject_fifo: per-execution-unit staging FIFO in front of a ring
// insertion port. Results are held until the ring slot at this position
// is free, and the execution unit is throttled with ready/valid so that
// no result is ever offered to an occupied slot and lost.
//
// Optional feature macro: RING_INJECT_BYPASS_EN
//   When defined, a result arriving at an empty FIFO with a free slot is
//   inserted in the same cycle without being written into storage.
module ring_inject_fifo #(
    parameter int XLEN          = 32,
    parameter int PHYS_REG_SIZE = 256,
    parameter int ROB_ENTRY     = 256,
    parameter int DEPTH         = 4,
    localparam int TAG_W        = $clog2(PHYS_REG_SIZE),
    localparam int ROB_W        = $clog2(ROB_ENTRY),
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_update_reg,
    input  logic [XLEN-1:0]  in_update_val,
    input  logic [ROB_W-1:0] in_rob_entry,
    input  logic             slot_busy,
    output logic             out_update,
    output logic [TAG_W-1:0] out_update_reg,
    output logic [XLEN-1:0]  out_update_val,
    output logic [ROB_W-1:0] out_rob_entry,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       stall_cnt
);

    // Payload storage; deliberately not reset.
    logic [TAG_W-1:0] r_reg_mem [DEPTH];
    logic [XLEN-1:0]  r_val_mem [DEPTH];
    logic [ROB_W-1:0] r_rob_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_stall_cnt;

    logic w_active;
    logic w_has_entry;
    logic w_pop;
    logic w_push;
    logic w_bypass;
    logic w_write;

    assign w_active    = rst && !flush;
    assign w_has_entry = (r_count != {CNT_W{1'b0}});
    assign in_ready    = w_active && (r_count < CNT_W'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_active && w_has_entry && !slot_busy;

`ifdef RING_INJECT_BYPASS_EN
    assign w_bypass    = w_active && !w_has_entry && in_valid && !slot_busy;
`else
    assign w_bypass    = 1'b0;
`endif

    // A bypassed result goes straight to the ring and never occupies storage.
    assign w_write     = w_push && !w_bypass;
    assign out_update  = w_pop || w_bypass;
    assign count       = r_count;
    assign stall_cnt   = r_stall_cnt;

    // Select the insertion payload: the head entry, or the live input when bypassing.
    always_comb begin
        out_update_reg = r_reg_mem[r_head];
        out_update_val = r_val_mem[r_head];
        out_rob_entry  = r_rob_mem[r_head];
        if (w_bypass) begin
            out_update_reg = in_update_reg;
            out_update_val = in_update_val;
            out_rob_entry  = in_rob_entry;
        end else begin
            out_update_reg = r_reg_mem[r_head];
            out_update_val = r_val_mem[r_head];
            out_rob_entry  = r_rob_mem[r_head];
        end
    end

    // Write accepted results into the tail slot of the payload storage.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_reg_mem[r_tail] <= in_update_reg;
            r_val_mem[r_tail] <= in_update_val;
            r_rob_mem[r_tail] <= in_rob_entry;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_write) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count consecutive cycles where a buffered head is held off by a busy slot.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_stall_cnt <= 8'd0;
        end else if (w_pop || !w_has_entry) begin
            r_stall_cnt <= 8'd0;
        end else if (slot_busy) begin
            if (r_stall_cnt != 8'hFF) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end else begin
            r_stall_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_ring_inject_fifo.sv
// Randomized and directed bench for ring_inject_fifo with a queue-based
// reference model (DEPTH=4, 8-bit tag and ROB index, 32-bit value).
module tb_ring_inject_fifo;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]  rg;
        logic [31:0] vl;
        logic [7:0]  rb;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_update_reg;
    logic [31:0] in_update_val;
    logic [7:0]  in_rob_entry;
    logic        slot_busy;
    logic        out_update;
    logic [7:0]  out_update_reg;
    logic [31:0] out_update_val;
    logic [7:0]  out_rob_entry;
    logic [2:0]  count;
    logic [7:0]  stall_cnt;

    ring_inject_fifo #(
        .XLEN(32), .PHYS_REG_SIZE(256), .ROB_ENTRY(256), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_update_reg(in_update_reg), .in_update_val(in_update_val),
        .in_rob_entry(in_rob_entry), .slot_busy(slot_busy),
        .out_update(out_update), .out_update_reg(out_update_reg),
        .out_update_val(out_update_val), .out_rob_entry(out_rob_entry),
        .count(count), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    entry_t q[$];
    int     m_stall = 0;
    bit     m_acc = 0;
    bit     e_ready = 0, e_pop = 0, e_byp = 0, e_upd = 0;
    entry_t e_head;
    bit     had;

    int vectors = 0;
    int miscompares = 0;

    // Producer state
    logic [7:0]  cur_reg = 8'h01;
    logic [31:0] cur_val = 32'h1000_0000;
    logic [7:0]  cur_rob = 8'h00;

    // Emission order tracker
    bit   track_en = 0;
    int   trk_next = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs, then check outputs mid-cycle against the model.
    task automatic drive_check(input logic r, input logic f, input logic v,
                               input logic [7:0] rg, input logic [31:0] vl,
                               input logic [7:0] rb, input logic b);
        rst = r; flush = f; in_valid = v;
        in_update_reg = rg; in_update_val = vl; in_rob_entry = rb; slot_busy = b;
        #2;
        e_byp = 1'b0;
`ifdef RING_INJECT_BYPASS_EN
        e_byp = r && !f && (q.size() == 0) && v && !b;
`endif
        e_ready = r && !f && (q.size() < DEPTH);
        e_pop   = r && !f && (q.size() != 0) && !b;
        e_upd   = e_pop || e_byp;
        chk("in_ready", {63'd0, in_ready}, {63'd0, e_ready});
        chk("out_update", {63'd0, out_update}, {63'd0, e_upd});
        chk("count", {61'd0, count}, 64'(q.size()));
        chk("stall_cnt", {56'd0, stall_cnt}, 64'(m_stall));
        if (e_byp || q.size() != 0) begin
            if (e_byp) e_head = '{rg: rg, vl: vl, rb: rb};
            else       e_head = q[0];
            chk("out_reg", {56'd0, out_update_reg}, {56'd0, e_head.rg});
            chk("out_val", {32'd0, out_update_val}, {32'd0, e_head.vl});
            chk("out_rob", {56'd0, out_rob_entry}, {56'd0, e_head.rb});
        end
        if (track_en && out_update === 1'b1) begin
            chk("order", {56'd0, out_rob_entry}, 64'(trk_next));
            chk("emit_when_free", {63'd0, slot_busy}, 64'd0);
            trk_next++;
        end
    endtask

    // Clock edge: advance the model by the specification's rules.
    task automatic advance();
        @(posedge clk);
        if (!rst || flush) begin
            q.delete();
            m_stall = 0;
            m_acc = 0;
        end else begin
            m_acc = in_valid && e_ready;
            had = (q.size() != 0);
            if (e_pop) void'(q.pop_front());
            if (m_acc && !e_byp) q.push_back('{rg: in_update_reg, vl: in_update_val, rb: in_rob_entry});
            if (e_pop || !had) m_stall = 0;
            else if (slot_busy) m_stall = (m_stall == 255) ? 255 : m_stall + 1;
            else m_stall = 0;
        end
        #1;
    endtask

    // One cycle of a producer holding its current result until accepted.
    task automatic produce(input logic r, input logic f, input logic b, input logic want);
        drive_check(r, f, want, cur_reg, cur_val, cur_rob, b);
        advance();
        if (m_acc) begin
            cur_rob = cur_rob + 8'd1;
            cur_reg = 8'($urandom);
            cur_val = $urandom;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) produce(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int busy_pct;
        int val_pct;
        // Reset held for two edges before any check
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; slot_busy = 1'b0;
        in_update_reg = 8'd0; in_update_val = 32'd0; in_rob_entry = 8'd0;
        advance();
        advance();
        drive_check(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0);
        chk("rst_ready_lit", {63'd0, in_ready}, 64'd0);
        chk("rst_count_lit", {61'd0, count}, 64'd0);
        advance();

        // Single result latency
        drive_check(1'b1, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 8'h10, 1'b0);
        chk("ready_after_rst_lit", {63'd0, in_ready}, 64'd1);
`ifdef RING_INJECT_BYPASS_EN
        chk("byp_upd_lit", {63'd0, out_update}, 64'd1);
        chk("byp_val_lit", {32'd0, out_update_val}, 64'hDEADBEEF);
`endif
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0);
`ifndef RING_INJECT_BYPASS_EN
        chk("lat_upd_lit", {63'd0, out_update}, 64'd1);
        chk("lat_reg_lit", {56'd0, out_update_reg}, 64'h05);
        chk("lat_val_lit", {32'd0, out_update_val}, 64'hDEADBEEF);
        chk("lat_rob_lit", {56'd0, out_rob_entry}, 64'h10);
`endif
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0);
        chk("lat_count_lit", {61'd0, count}, 64'd0);
        advance();

        // Fill to full under a busy slot, then release
        for (int i = 0; i < 5; i++) produce(1'b1, 1'b0, 1'b1, 1'b1);
        drive_check(1'b1, 1'b0, 1'b1, cur_reg, cur_val, cur_rob, 1'b1);
        chk("full_count_lit", {61'd0, count}, 64'd4);
        chk("full_ready_lit", {63'd0, in_ready}, 64'd0);
        chk("full_stall_lit", {56'd0, stall_cnt}, 64'd4);
        advance();
        for (int i = 0; i < 3; i++) produce(1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        // Alternating slot_busy with ROB indices 0..15
        cur_rob = 8'd0;
        track_en = 1;
        trk_next = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cur_rob >= 8'd16 && q.size() == 0) break;
            produce(1'b1, 1'b0, cyc[0], cur_rob < 8'd16);
        end
        track_en = 0;
        chk("order_total", 64'(trk_next), 64'd16);

        // Flush at count 3 together with a push
        for (int i = 0; i < 3; i++) produce(1'b1, 1'b0, 1'b1, 1'b1);
        drive_check(1'b1, 1'b1, 1'b1, cur_reg, cur_val, cur_rob, 1'b1);
        chk("flush_ready_lit", {63'd0, in_ready}, 64'd0);
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1);
        chk("flush_count_lit", {61'd0, count}, 64'd0);
        chk("flush_upd_lit", {63'd0, out_update}, 64'd0);
        chk("flush_stall_lit", {56'd0, stall_cnt}, 64'd0);
        advance();
        for (int i = 0; i < 3; i++) produce(1'b1, 1'b0, 1'b0, 1'b0);

        // Stall counter saturation
        produce(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1);
            advance();
        end
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1);
        chk("sat_stall_lit", {56'd0, stall_cnt}, 64'd255);
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0);
        chk("sat_pop_lit", {63'd0, out_update}, 64'd1);
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0);
        chk("sat_clear_lit", {56'd0, stall_cnt}, 64'd0);
        advance();

        // One-cycle reset at count 2
        produce(1'b1, 1'b0, 1'b1, 1'b1);
        produce(1'b1, 1'b0, 1'b1, 1'b1);
        drive_check(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1);
        chk("mid_rst_ready_lit", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_count_lit", {61'd0, count}, 64'd2);
        advance();
        drive_check(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1);
        chk("post_rst_ready_lit", {63'd0, in_ready}, 64'd1);
        chk("post_rst_count_lit", {61'd0, count}, 64'd0);
        advance();

        // Randomized traffic with varying densities, rare flush and reset
        busy_pct = 50;
        val_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                busy_pct = $urandom_range(0, 100);
                val_pct = $urandom_range(10, 100);
            end
            produce($urandom_range(0, 127) != 0, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 99) < busy_pct, $urandom_range(0, 99) < val_pct);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
